harry_motion_ctrl: RTL and testbench

//  Motion/pose sequencer for the Harry player sprite. Owns the player FSM
//  (run, jump, duck, dead, float), the vertical physics (row, velocity) and
//  the run/duck animation phase. Drives the sprite renderer with a top row and
//  a sprite select; sits between the key decoder / game-over logic and the

---
 rtl/harry_motion_ctrl_if.sv | 23 ++
 rtl/harry_motion_ctrl.sv | 153 +++++++++++++++
 tb/tb_harry_motion_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/harry_motion_ctrl_if.sv
// Control/pose bundle between the key decoder, the motion sequencer
// and the sprite renderer.
interface harry_motion_ctrl_if;
    logic       i_game_over;
    logic       i_cheat;
    logic [1:0] i_key;
    logic       i_game_tick;
    logic [8:0] o_pos_row;
    logic [2:0] o_sprite_sel;
    logic       o_jumping;
    logic       o_ducking;
    logic       o_land_pulse;

    modport master (
        output i_game_over, i_cheat, i_key, i_game_tick,
        input  o_pos_row, o_sprite_sel, o_jumping, o_ducking, o_land_pulse
    );

    modport slave (
        input  i_game_over, i_cheat, i_key, i_game_tick,
        output o_pos_row, o_sprite_sel, o_jumping, o_ducking, o_land_pulse
    );
endinterface

// File: rtl/harry_motion_ctrl.sv
// Harry player sequencer: pose FSM, vertical physics on a slow tick,
// and run/duck animation phase, all outputs registered.
module harry_motion_ctrl #(
    parameter int GROUND    = 300,
    parameter int FLOAT_ROW = 100,
    parameter int INIT_V    = 15,
    parameter int GRAV      = 1,
    parameter int TICK_W    = 19,
    parameter int ANIM_N    = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    harry_motion_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_RUN, S_JUMP, S_DUCK, S_DEAD, S_FLOAT
    } state_t;

    localparam int         AW       = (ANIM_N > 1) ? $clog2(ANIM_N) : 1;
    localparam logic [8:0] ROW_GND  = 9'(GROUND);
    localparam logic [8:0] ROW_FLT  = 9'(FLOAT_ROW);
    localparam logic [5:0] V_LAUNCH = 6'(64 - INIT_V);

    state_t            r_state;
    logic [8:0]        r_row;
    logic [5:0]        r_v;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [AW-1:0]     r_anim_cnt;
    logic              r_phase;
    logic [2:0]        r_sel;
    logic              r_jump;
    logic              r_duck;
    logic              r_land;

    state_t            w_state_n;
    logic [8:0]        w_row_n;
    logic [5:0]        w_v_n;
    logic              w_land_n;
    logic [2:0]        w_sel_n;
    logic              w_tick;
    logic              w_anim_wrap;
    logic              w_phase_n;
    logic signed [9:0] w_sum;
    logic [6:0]        w_vsum;
    logic [5:0]        w_vinc;
    logic [8:0]        w_row_clamp;
    logic              w_hit_gnd;

    assign w_tick      = &r_tick_cnt;
    assign w_anim_wrap = bus.i_game_tick
                       && (r_anim_cnt == AW'(ANIM_N - 1));
    assign w_phase_n   = r_phase ^ w_anim_wrap;

    // Row math in 10-bit signed so both ground and ceiling overshoot are visible
    assign w_sum       = $signed({1'b0, r_row})
                       + $signed({{4{r_v[5]}}, r_v});
    assign w_hit_gnd   = w_sum >= $signed(10'(GROUND));
    assign w_row_clamp = w_sum[9] ? 9'd0 : w_sum[8:0];
    assign w_vsum      = {r_v[5], r_v} + 7'(GRAV);
    assign w_vinc      = (!w_vsum[6] && w_vsum[5]) ? 6'd31 : w_vsum[5:0];

    always_comb begin
        w_state_n = r_state;
        w_row_n   = r_row;
        w_v_n     = r_v;
        w_land_n  = 1'b0;
        if (bus.i_game_over) begin
            w_state_n = S_DEAD;
        end else if (bus.i_cheat && r_state != S_DEAD) begin
            w_state_n = S_FLOAT;
            w_row_n   = ROW_FLT;
            w_v_n     = '0;
        end else if (w_tick) begin
            unique case (r_state)
                S_RUN, S_DUCK: begin
                    if (bus.i_key == 2'b01) begin
                        w_state_n = S_JUMP;
                        w_v_n     = V_LAUNCH;
                    end else if (bus.i_key == 2'b10) begin
                        w_state_n = S_DUCK;
                    end else begin
                        w_state_n = S_RUN;
                    end
                end
                S_JUMP: begin
                    if (w_hit_gnd) begin
                        w_state_n = S_RUN;
                        w_row_n   = ROW_GND;
                        w_v_n     = '0;
                        w_land_n  = 1'b1;
                    end else begin
                        w_row_n = w_row_clamp;
                        w_v_n   = w_vinc;
                    end
                end
                S_FLOAT: begin
                    w_state_n = S_JUMP;
                    w_v_n     = '0;
                end
                S_DEAD: begin
                    w_state_n = S_RUN;
                    w_row_n   = ROW_GND;
                    w_v_n     = '0;
                end
                default: w_state_n = S_RUN;
            endcase
        end
    end

    always_comb begin
        w_sel_n = {2'b00, w_phase_n};
        unique case (1'b1)
            (w_state_n == S_DEAD):  w_sel_n = 3'd5;
            (w_state_n == S_JUMP),
            (w_state_n == S_FLOAT): w_sel_n = 3'd2;
            (w_state_n == S_DUCK):  w_sel_n = 3'd3 + {2'b00, w_phase_n};
            default:                w_sel_n = {2'b00, w_phase_n};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_row      <= ROW_GND;
            r_v        <= '0;
            r_tick_cnt <= '0;
            r_anim_cnt <= '0;
            r_phase    <= 1'b0;
            r_sel      <= '0;
            r_jump     <= 1'b0;
            r_duck     <= 1'b0;
            r_land     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_row      <= w_row_n;
            r_v        <= w_v_n;
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            if (bus.i_game_tick)
                r_anim_cnt <= w_anim_wrap ? '0 : r_anim_cnt + AW'(1);
            r_phase    <= w_phase_n;
            r_sel      <= w_sel_n;
            r_jump     <= (w_state_n == S_JUMP) || (w_state_n == S_FLOAT);
            r_duck     <= (w_state_n == S_DUCK);
            r_land     <= w_land_n;
        end
    end

    assign bus.o_pos_row    = r_row;
    assign bus.o_sprite_sel = r_sel;
    assign bus.o_jumping    = r_jump;
    assign bus.o_ducking    = r_duck;
    assign bus.o_land_pulse = r_land;
endmodule

// File: tb/tb_harry_motion_ctrl.sv
// Bench for harry_motion_ctrl: directed table, landing / reset corners,
// then randomized inputs against a behavioural player model.
module tb_harry_motion_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    harry_motion_ctrl_if bus();

    harry_motion_ctrl #(.TICK_W(2), .ANIM_N(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [14:0] RST_VAL = {9'd300, 3'd0, 1'b0, 1'b0, 1'b0};

    typedef enum {M_RUN, M_JUMP, M_DUCK, M_DEAD, M_FLOAT} mst_t;
    mst_t m_st;
    int   m_row, m_v, m_cyc, m_anim, m_phase;
    bit   m_land;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_land = 0;

    typedef struct {
        logic [1:0] key;
        logic       cheat;
        logic       go;
        int         n;
        int         row;
        int         sel;
        logic       j;
        logic       d;
    } vec_t;
    vec_t tbl [18];

    function automatic void m_reset();
        m_st = M_RUN; m_row = 300; m_v = 0; m_cyc = 0;
        m_anim = 0; m_phase = 0; m_land = 0;
    endfunction

    // Player rules in plain integer arithmetic; tick every 4th clk
    function automatic void m_step(logic [1:0] k, logic c, logic g, logic t);
        bit tick;
        int nr;
        tick = (m_cyc % 4) == 3;
        m_cyc++;
        if (t) begin
            if (m_anim == 1) begin m_anim = 0; m_phase ^= 1; end
            else m_anim++;
        end
        m_land = 0;
        if (g) m_st = M_DEAD;
        else if (c && m_st != M_DEAD) begin
            m_st = M_FLOAT; m_row = 100; m_v = 0;
        end else if (tick) begin
            case (m_st)
                M_RUN, M_DUCK: begin
                    if (k == 2'b01) begin m_st = M_JUMP; m_v = -15; end
                    else if (k == 2'b10) m_st = M_DUCK;
                    else m_st = M_RUN;
                end
                M_JUMP: begin
                    nr = m_row + m_v;
                    if (nr >= 300) begin
                        m_row = 300; m_v = 0; m_st = M_RUN; m_land = 1;
                    end else begin
                        m_row = (nr < 0) ? 0 : nr;
                        m_v = (m_v + 1 > 31) ? 31 : m_v + 1;
                    end
                end
                M_FLOAT: begin m_st = M_JUMP; m_v = 0; end
                default: begin m_st = M_RUN; m_row = 300; m_v = 0; end
            endcase
        end
    endfunction

    function automatic logic [14:0] m_exp();
        int s;
        case (m_st)
            M_DEAD:          s = 5;
            M_JUMP, M_FLOAT: s = 2;
            M_DUCK:          s = 3 + m_phase;
            default:         s = m_phase;
        endcase
        return {9'(m_row), 3'(s), m_st == M_JUMP || m_st == M_FLOAT,
                m_st == M_DUCK, m_land};
    endfunction

    function automatic logic [14:0] act();
        return {bus.o_pos_row, bus.o_sprite_sel, bus.o_jumping,
                bus.o_ducking, bus.o_land_pulse};
    endfunction

    task automatic check(string nm, logic [14:0] a, logic [14:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: dut row=%0d sel=%0d j=%0b d=%0b land=%0b, want row=%0d sel=%0d j=%0b d=%0b land=%0b",
                     nm, a[14:6], a[5:3], a[2], a[1], a[0],
                     e[14:6], e[5:3], e[2], e[1], e[0]);
        end
    endtask

    task automatic cyc(logic [1:0] k, logic c, logic g, logic t);
        bus.i_key = k; bus.i_cheat = c; bus.i_game_over = g;
        bus.i_game_tick = t;
        @(posedge clk);
        #1;
        m_step(k, c, g, t);
        if (bus.o_land_pulse === 1'b1) n_land++;
        check("model", act(), m_exp());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #2;
        check("reset", act(), RST_VAL);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int lb;
        bus.i_key = 2'b00; bus.i_cheat = 1'b0;
        bus.i_game_over = 1'b0; bus.i_game_tick = 1'b0;
        tbl[0]  = '{2'b00, 1'b0, 1'b0, 4,  300, 0, 1'b0, 1'b0};
        tbl[1]  = '{2'b11, 1'b0, 1'b0, 4,  300, 0, 1'b0, 1'b0};
        tbl[2]  = '{2'b10, 1'b0, 1'b0, 4,  300, 3, 1'b0, 1'b1};
        tbl[3]  = '{2'b00, 1'b0, 1'b0, 4,  300, 0, 1'b0, 1'b0};
        tbl[4]  = '{2'b01, 1'b0, 1'b0, 4,  300, 2, 1'b1, 1'b0};
        tbl[5]  = '{2'b00, 1'b0, 1'b0, 4,  285, 2, 1'b1, 1'b0};
        tbl[6]  = '{2'b10, 1'b0, 1'b0, 4,  271, 2, 1'b1, 1'b0};
        tbl[7]  = '{2'b00, 1'b0, 1'b0, 52, 180, 2, 1'b1, 1'b0};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 4,  180, 5, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 1'b0, 1'b0, 4,  300, 0, 1'b0, 1'b0};
        tbl[10] = '{2'b00, 1'b1, 1'b0, 4,  100, 2, 1'b1, 1'b0};
        tbl[11] = '{2'b00, 1'b1, 1'b1, 4,  100, 5, 1'b0, 1'b0};
        tbl[12] = '{2'b00, 1'b0, 1'b0, 4,  300, 0, 1'b0, 1'b0};
        tbl[13] = '{2'b00, 1'b1, 1'b0, 4,  100, 2, 1'b1, 1'b0};
        tbl[14] = '{2'b00, 1'b0, 1'b0, 4,  100, 2, 1'b1, 1'b0};
        tbl[15] = '{2'b00, 1'b0, 1'b0, 4,  100, 2, 1'b1, 1'b0};
        tbl[16] = '{2'b00, 1'b0, 1'b0, 4,  101, 2, 1'b1, 1'b0};
        tbl[17] = '{2'b00, 1'b0, 1'b0, 4,  103, 2, 1'b1, 1'b0};

        #3;
        do_reset();

        for (int i = 0; i < 18; i++) begin
            repeat (tbl[i].n) cyc(tbl[i].key, tbl[i].cheat, tbl[i].go, 1'b0);
            check($sformatf("tbl%0d", i), act(),
                  {9'(tbl[i].row), 3'(tbl[i].sel), tbl[i].j, tbl[i].d, 1'b0});
        end

        // Fall from the float release down to ground: exactly one pulse
        lb = n_land;
        for (int i = 0; i < 400 && n_land == lb; i++) cyc(2'b00, 0, 0, 0);
        repeat (8) cyc(2'b00, 0, 0, 0);
        check("land_once", 15'(n_land - lb), 15'd1);
        check("landed", act(), RST_VAL);

        // Animation toggles every two game_tick pulses while running
        repeat (12) cyc(2'b00, 0, 0, 1'b1);

        // Async reset in mid-air, between clock edges
        repeat (8) cyc(2'b01, 0, 0, 0);
        repeat (10) cyc(2'b00, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("async_rst", act(), RST_VAL);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold", act(), RST_VAL);
        end
        rst_n = 1'b1;

        for (int it = 0; it < 400; it++) begin
            int hold;
            logic [1:0] k;
            logic c, g;
            hold = $urandom_range(1, 8);
            k = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 15) == 0);
            g = ($urandom_range(0, 19) == 0);
            repeat (hold) cyc(k, c, g, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
